// File: rtl/pb_pkg.sv
// Shared constants, types and helpers for the pushbutton mode-select front end.
package pb_pkg;

    localparam int MODE_TOGGLE         = 0;
    localparam int MODE_COUNT          = 1;
    localparam int DEBOUNCE_SIM        = 4;
    localparam int DEBOUNCE_50MHZ_10MS = 500000;

    typedef enum logic [1:0] {
        STEP_HOLD,
        STEP_UP,
        STEP_DOWN
    } step_e;

    // Toggle style needs one bit per button; counter style needs enough bits for NUM_MODES.
    function automatic int calc_mode_w(input int num_pb, input int style, input int num_modes);
        if (style == MODE_TOGGLE) begin
            return num_pb;
        end
        return (num_modes <= 2) ? 1 : $clog2(num_modes);
    endfunction

endpackage

// File: rtl/pb_mode_select_if.sv
// Pin and mode-word bundle between the board pushbuttons and the mode select block.
interface pb_mode_select_if #(
    parameter int NUM_PB = 2,
    parameter int MODE_W = 2
);
    logic [NUM_PB-1:0] PB;
    logic [MODE_W-1:0] mode;
    logic [NUM_PB-1:0] press;
    logic [NUM_PB-1:0] pb_level;
    logic              mode_changed;

    modport master (
        output PB,
        input  mode,
        input  press,
        input  pb_level,
        input  mode_changed
    );

    modport slave (
        input  PB,
        output mode,
        output press,
        output pb_level,
        output mode_changed
    );

endinterface

// File: rtl/pb_debounce.sv
// One pushbutton: 2-flop synchroniser, polarity normalisation, counter debounce
// and a registered press pulse aligned with the debounced level rise.
module pb_debounce #(
    parameter int PB_ACTIVE_LOW   = 1,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pb,
    output logic o_level,
    output logic o_press
);

    localparam int             CW           = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST     = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic           RELEASED_PIN = (PB_ACTIVE_LOW != 0);

    logic          r_sync1;
    logic          r_sync2;
    logic [1:0]    r_warm;
    logic [CW-1:0] r_cnt;
    logic          r_lvl;
    logic          r_level;
    logic          r_press;
    logic          w_synced;
    logic          w_accept;

    assign w_synced = r_sync2 ^ RELEASED_PIN;
    assign w_accept = r_warm[1] && (w_synced != r_lvl) && (r_cnt == CNT_LAST);

    // r_lvl restarts as "pressed" so a button held through reset must first be
    // seen released before it can produce a press; o_level still reads 0 until then.
    // r_warm keeps the reset contents of the synchroniser out of the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= RELEASED_PIN;
            r_sync2 <= RELEASED_PIN;
            r_warm  <= 2'b00;
            r_cnt   <= '0;
            r_lvl   <= 1'b1;
            r_level <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_sync1 <= i_pb;
            r_sync2 <= r_sync1;
            r_warm  <= {r_warm[0], 1'b1};
            r_press <= w_accept & w_synced;
            if (!r_warm[1] || (w_synced == r_lvl)) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_cnt   <= '0;
                r_lvl   <= w_synced;
                r_level <= w_synced;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_level = r_level;
    assign o_press = r_press;

endmodule

// File: rtl/pb_mode_select.sv
// Pushbutton front end: per-button debounce plus a registered mode word updated
// either by per-button toggles or by an up/down wrapping counter.
module pb_mode_select
    import pb_pkg::*;
#(
    parameter int NUM_PB          = 2,
    parameter int PB_ACTIVE_LOW   = 1,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_50MHZ_10MS,
    parameter int MODE_STYLE      = MODE_TOGGLE,
    parameter int NUM_MODES       = 3,
    parameter int INIT_MODE       = 0
) (
    input  logic             clk,
    input  logic             rst,
    pb_mode_select_if.slave  bus
);

    localparam int MODE_W = calc_mode_w(NUM_PB, MODE_STYLE, NUM_MODES);
    localparam logic [MODE_W-1:0] INIT_VAL =
        ((MODE_STYLE == MODE_COUNT) && (INIT_MODE >= NUM_MODES)) ? '0 : MODE_W'(INIT_MODE);

    logic [NUM_PB-1:0] w_level;
    logic [NUM_PB-1:0] w_press;
    logic [MODE_W-1:0] w_modeNext;
    logic [MODE_W-1:0] r_mode;
    logic [MODE_W-1:0] r_modePrev;
    logic              r_modeChanged;

    for (genvar g = 0; g < NUM_PB; g++) begin : g_pb
        pb_debounce #(
            .PB_ACTIVE_LOW  (PB_ACTIVE_LOW),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk    (clk),
            .rst    (rst),
            .i_pb   (bus.PB[g]),
            .o_level(w_level[g]),
            .o_press(w_press[g])
        );
    end

    if (MODE_STYLE == MODE_COUNT) begin : g_count
        localparam logic [MODE_W-1:0] MAX_MODE = MODE_W'(NUM_MODES - 1);
        step_e w_step;

        // Button 0 steps up, button 1 steps down; both at once cancel out.
        always_comb begin
            w_step     = STEP_HOLD;
            w_modeNext = r_mode;
            if (w_press[0] && !w_press[1]) begin
                w_step = STEP_UP;
            end else if (w_press[1] && !w_press[0]) begin
                w_step = STEP_DOWN;
            end
            case (w_step)
                STEP_UP:   w_modeNext = (r_mode == MAX_MODE) ? '0 : r_mode + MODE_W'(1);
                STEP_DOWN: w_modeNext = (r_mode == '0) ? MAX_MODE : r_mode - MODE_W'(1);
                default:   w_modeNext = r_mode;
            endcase
        end
    end else begin : g_toggle
        always_comb begin
            w_modeNext = r_mode ^ w_press;
        end
    end

    // mode_changed compares the last two mode values, so it trails the update by one clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode        <= INIT_VAL;
            r_modePrev    <= INIT_VAL;
            r_modeChanged <= 1'b0;
        end else begin
            r_mode        <= w_modeNext;
            r_modePrev    <= r_mode;
            r_modeChanged <= (r_mode != r_modePrev);
        end
    end

    assign bus.mode         = r_mode;
    assign bus.press        = w_press;
    assign bus.pb_level     = w_level;
    assign bus.mode_changed = r_modeChanged;

endmodule
